// File: rtl/encoder_pkg.sv
// Shared widths, index codes and the population-count helper for the 4-to-2 encoder.
package encoder_pkg;
    localparam int IN_W  = 4;
    localparam int OUT_W = 2;
    localparam int CNT_W = 3;

    localparam logic [OUT_W-1:0] IDX0 = 2'd0;
    localparam logic [OUT_W-1:0] IDX1 = 2'd1;
    localparam logic [OUT_W-1:0] IDX2 = 2'd2;
    localparam logic [OUT_W-1:0] IDX3 = 2'd3;

    function automatic logic [CNT_W-1:0] popcount(input logic [IN_W-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < IN_W; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction
endpackage

// File: rtl/encoder_4_2_core.sv
// Combinational priority encode of the enable-gated request vector.
module encoder_4_2_core
    import encoder_pkg::*;
#(
    parameter bit HIGH_PRIO = 1'b1
) (
    input  logic [IN_W-1:0]  in,
    input  logic             en,
    output logic [OUT_W-1:0] y_c,
    output logic             valid_c,
    output logic             multi_c
);
    logic [IN_W-1:0] gated;

    // Masking with en first keeps unknown request bits out of every output while disabled.
    assign gated = in & {IN_W{en}};

    always_comb begin
        y_c = IDX0;
        if (HIGH_PRIO) begin
            if (gated[3])      y_c = IDX3;
            else if (gated[2]) y_c = IDX2;
            else if (gated[1]) y_c = IDX1;
            else               y_c = IDX0;
        end else begin
            if (gated[0])      y_c = IDX0;
            else if (gated[1]) y_c = IDX1;
            else if (gated[2]) y_c = IDX2;
            else if (gated[3]) y_c = IDX3;
            else               y_c = IDX0;
        end
    end

    assign valid_c = |gated;
    assign multi_c = (popcount(gated) > CNT_W'(1));
endmodule

// File: rtl/encoder_4_2.sv
// Registered 4-to-2 priority encoder: reset synchroniser plus output flops around the core.
module encoder_4_2
    import encoder_pkg::*;
#(
    parameter bit HIGH_PRIO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    input  logic             en,
    output logic [OUT_W-1:0] y,
    output logic             valid,
    output logic             multi
);
    logic [1:0]       rst_sync;
    logic             rst_int_n;
    logic [OUT_W-1:0] y_c;
    logic             valid_c;
    logic             multi_c;

    // Assert passes straight through; release reaches the output flops two edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_int_n = rst_sync[1];

    encoder_4_2_core #(
        .HIGH_PRIO (HIGH_PRIO)
    ) u_core (
        .in      (in),
        .en      (en),
        .y_c     (y_c),
        .valid_c (valid_c),
        .multi_c (multi_c)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            y     <= IDX0;
            valid <= 1'b0;
            multi <= 1'b0;
        end else begin
            y     <= y_c;
            valid <= valid_c;
            multi <= multi_c;
        end
    end
endmodule

// File: tb/tb_encoder_4_2.sv
// Directed bench for encoder_4_2, driving a highest- and a lowest-priority instance in parallel.
module tb_encoder_4_2;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in;
    logic       en;
    logic [1:0] y_hi, y_lo;
    logic       valid_hi, valid_lo, multi_hi, multi_lo;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       en;
        logic [3:0] in;
        logic [1:0] y_hi;
        logic [1:0] y_lo;
        logic       valid;
        logic       multi;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    encoder_4_2 #(.HIGH_PRIO(1'b1)) dut_hi (
        .clk (clk), .rst_n (rst_n), .in (in), .en (en),
        .y (y_hi), .valid (valid_hi), .multi (multi_hi)
    );

    encoder_4_2 #(.HIGH_PRIO(1'b0)) dut_lo (
        .clk (clk), .rst_n (rst_n), .in (in), .en (en),
        .y (y_lo), .valid (valid_lo), .multi (multi_lo)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {y,valid,multi}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic check_both(input string name, input logic [1:0] ehi, input logic [1:0] elo,
                              input logic ev, input logic em);
        check({name, "_hi"}, {y_hi, valid_hi, multi_hi}, {ehi, ev, em});
        check({name, "_lo"}, {y_lo, valid_lo, multi_lo}, {elo, ev, em});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'b0001, 2'b00, 2'b00, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 4'b0010, 2'b01, 2'b01, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 4'b0100, 2'b10, 2'b10, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 4'b1000, 2'b11, 2'b11, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 4'b1010, 2'b11, 2'b01, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'b1111, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'b0110, 2'b10, 2'b01, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 4'b0111, 2'b10, 2'b00, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 4'b1111, 2'b11, 2'b00, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 4'b1001, 2'b11, 2'b00, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 4'b0011, 2'b01, 2'b00, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 4'b1100, 2'b11, 2'b10, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 4'b0101, 2'b00, 2'b00, 1'b0, 1'b0};

        // Reset held while inputs toggle: outputs stay cleared.
        rst_n = 1'b0;
        en    = 1'b1;
        in    = 4'b1000;
        #1;
        check_both("reset_initial", 2'b00, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_both("reset_hold", 2'b00, 2'b00, 1'b0, 1'b0);
            en = ~en;
            in = ~in;
        end

        // Release, then let the synchroniser settle with the encoder idle.
        rst_n = 1'b1;
        en    = 1'b0;
        in    = 4'b0000;
        repeat (3) step();

        for (int i = 0; i < 14; i++) begin
            en = vecs[i].en;
            in = vecs[i].in;
            step();
            check_both($sformatf("vec%0d", i), vecs[i].y_hi, vecs[i].y_lo, vecs[i].valid, vecs[i].multi);
        end

        // Disabled with unknown requests.
        en = 1'b0;
        in = 4'bxxxx;
        step();
        check_both("en0_x", 2'b00, 2'b00, 1'b0, 1'b0);
        checks++;
        if ($isunknown({y_hi, valid_hi, multi_hi, y_lo, valid_lo, multi_lo})) begin
            failures++;
            $display("FAIL en0_x_known: outputs hi=%b%b%b lo=%b%b%b expected no X",
                     y_hi, valid_hi, multi_hi, y_lo, valid_lo, multi_lo);
        end

        // Reset mid-stream: registered result must drop at once and not reappear early.
        en = 1'b1;
        in = 4'b1000;
        step();
        check_both("mid_before", 2'b11, 2'b11, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_both("mid_async", 2'b00, 2'b00, 1'b0, 1'b0);
        step();
        check_both("mid_edge_ignored", 2'b00, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check_both("mid_sync1", 2'b00, 2'b00, 1'b0, 1'b0);
        step();
        check_both("mid_sync2", 2'b00, 2'b00, 1'b0, 1'b0);
        step();
        check_both("mid_first_edge", 2'b11, 2'b11, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
